// File: rtl/addsub_16b_pipe.sv
// addsub_16b_pipe -- two-stage 16-bit add/subtract unit for the execute stage.
// Stage 1 adds the low byte and registers the inter-byte carry. Stage 2 adds
// the high byte and produces the result and the cout/ofl/zero/neg flags.
// Both ends use valid/ready, and the unit sustains one op per cycle.
// Optional build macro ADDSUB_SAT_EN: on signed overflow, sum saturates to
// 0x7FFF or 0x8000 instead of wrapping.
module addsub_16b_pipe #(
  parameter int WIDTH = 16,
  parameter int SPLIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_inv,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ofl,
  output logic             zero,
  output logic             neg
);

  localparam int HI_W = WIDTH - SPLIT;

  // Stage 1 state: the low-byte result, the carry into the high byte, and the
  // high operand bytes waiting for stage 2.
  logic             s1_valid_reg;
  logic [SPLIT-1:0] lo_reg;
  logic             c8_reg;
  logic [HI_W-1:0]  a_hi_reg;
  logic [HI_W-1:0]  b_hi_reg;

  // Stage 2 state: the result registers that drive the outputs.
  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ofl_reg;
  logic             zero_reg;
  logic             neg_reg;

  logic             s2_adv;
  logic             accept;
  logic [SPLIT:0]   lo_add;
  logic [HI_W:0]    hi_add;
  logic [WIDTH-1:0] sum_wrap;
  logic [WIDTH-1:0] sum_next;
  logic             ofl_next;

  // Stage 2 can take new data when it is empty or its result leaves this cycle.
  assign s2_adv   = !out_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_adv;
  assign accept   = in_valid && in_ready;

  // Carry-in is sub. This completes the two's complement of ~B.
  assign lo_add   = {1'b0, a[SPLIT-1:0]} + {1'b0, b_inv[SPLIT-1:0]}
                  + {{SPLIT{1'b0}}, sub};
  assign hi_add   = {1'b0, a_hi_reg} + {1'b0, b_hi_reg} + {{HI_W{1'b0}}, c8_reg};
  assign sum_wrap = {hi_add[HI_W-1:0], lo_reg};

  // Overflow means the operand signs match but the result sign differs.
  assign ofl_next = (a_hi_reg[HI_W-1] == b_hi_reg[HI_W-1]) &&
                    (sum_wrap[WIDTH-1] != a_hi_reg[HI_W-1]);

`ifdef ADDSUB_SAT_EN
  // On overflow, clamp the result toward the sign of operand A.
  always_comb begin
    sum_next = sum_wrap;
    if (ofl_next) begin
      if (a_hi_reg[HI_W-1]) begin
        sum_next = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        sum_next = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end
`else
  assign sum_next = sum_wrap;
`endif

  // Stage 1: capture the low-byte add on accept, and empty once the op moves on.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      lo_reg       <= '0;
      c8_reg       <= 1'b0;
      a_hi_reg     <= '0;
      b_hi_reg     <= '0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      lo_reg       <= lo_add[SPLIT-1:0];
      c8_reg       <= lo_add[SPLIT];
      a_hi_reg     <= a[WIDTH-1:SPLIT];
      b_hi_reg     <= b_inv[WIDTH-1:SPLIT];
    end else if (s2_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Stage 2: finish the high byte and flags. Hold everything while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ofl_reg       <= 1'b0;
      zero_reg      <= 1'b0;
      neg_reg       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum_reg  <= sum_next;
        cout_reg <= hi_add[HI_W];
        ofl_reg  <= ofl_next;
        zero_reg <= (sum_next == '0);
        neg_reg  <= sum_next[WIDTH-1];
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ofl       = ofl_reg;
  assign zero      = zero_reg;
  assign neg       = neg_reg;

endmodule

// File: tb/tb_addsub_16b_pipe.sv
// tb_addsub_16b_pipe -- scoreboard bench for addsub_16b_pipe. Expected results
// come from integer arithmetic on whole 16-bit operands.
module tb_addsub_16b_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b_inv = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout, ofl, zero, neg;

  addsub_16b_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b_inv(b_inv), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ofl(ofl),
    .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ofl;
    logic        zero;
    logic        neg;
  } res_t;

  res_t exp_q[$];
  int   cyc_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   lat_check = 1'b0;
  bit   bp_phase = 1'b0;
  int   ready_low_seen = 0;
  bit   stalled = 1'b0;
  res_t held;

  // Reference model: whole-word unsigned and signed integer arithmetic.
  function automatic res_t model(input logic [15:0] aa, input logic [15:0] bb,
                                 input logic s);
    res_t r;
    int unsigned full;
    int          sv;
    full   = int'(aa) + int'(bb) + int'(s);
    sv     = int'($signed(aa)) + int'($signed(bb)) + int'(s);
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ofl  = (sv > 32767) || (sv < -32768);
`ifdef ADDSUB_SAT_EN
    if (r.ofl) r.sum = aa[15] ? 16'h8000 : 16'h7FFF;
`endif
    r.zero = (r.sum == 16'h0000);
    r.neg  = r.sum[15];
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Record every accepted op. Reset drops whatever was in flight.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      cyc_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back(model(a, b_inv, sub));
      cyc_q.push_back(cyc);
    end
    if (bp_phase && in_valid && !in_ready) ready_low_seen++;
  end

  // Monitor: check each output transfer, and check that a stalled result holds.
  always @(negedge clk) begin
    res_t got;
    res_t e;
    int   c;
    got = '{sum: sum, cout: cout, ofl: ofl, zero: zero, neg: neg};
    if (!rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        total++;
        if (!out_valid || got !== held) begin
          bad++;
          $display("FAIL stall_hold: got valid=%0b %h want valid=1 %h", out_valid, got, held);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        n_out++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got %h want no output", got);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL result #%0d: got sum=%h c=%b o=%b z=%b n=%b want sum=%h c=%b o=%b z=%b n=%b",
                     n_out, got.sum, got.cout, got.ofl, got.zero, got.neg,
                     e.sum, e.cout, e.ofl, e.zero, e.neg);
          end else begin
            $display("out #%0d sum=%h cout=%b ofl=%b zero=%b neg=%b ok",
                     n_out, got.sum, got.cout, got.ofl, got.zero, got.neg);
          end
          if (lat_check) begin
            total++;
            if (cyc - c != 2) begin
              bad++;
              $display("FAIL latency #%0d: got %0d want 2", n_out, cyc - c);
            end
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = got;
    end
  end

  // Present one op, hold it until it is accepted, and return just after that edge.
  task automatic send(input logic [15:0] aa, input logic [15:0] bb, input logic s);
    int n;
    n = 0;
    in_valid = 1'b1;
    a = aa;
    b_inv = bb;
    sub = s;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles want 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || ofl !== 1'b0 ||
        zero !== 1'b0 || neg !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s: got ov=%b sum=%h c=%b o=%b z=%b n=%b ir=%b want ov=0 sum=0000 flags=0 ir=1",
               tag, out_valid, sum, cout, ofl, zero, neg, in_ready);
    end else begin
      $display("%s ok", tag);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d results outstanding want 0", tag, exp_q.size());
    end
  endtask

  bit rand_done;

  initial begin
    logic [15:0] bb;
    logic        ss;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check_reset_state("reset_init");
    @(posedge clk);
    #1;

    // Directed cases, with the two-cycle latency checked.
    lat_check = 1'b1;
    send(16'h00FF, 16'h0001, 1'b0);
    send(16'h0005, ~16'h0005, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h0003, ~16'h0005, 1'b1);
    send(16'h8000, ~16'h0001, 1'b1);
    send(16'hFFFF, 16'h0001, 1'b0);
    drain("drain_directed");

    // Backpressure: four ops back to back, with the output stalled for several cycles.
    lat_check = 1'b0;
    bp_phase  = 1'b1;
    out_ready = 1'b0;
    fork
      begin
        send(16'h1111, 16'h2222, 1'b0);
        send(16'h8001, 16'h8001, 1'b0);
        send(16'h4000, ~16'h4000, 1'b1);
        send(16'h7000, 16'h1000, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    bp_phase = 1'b0;
    drain("drain_backpressure");
    total++;
    if (ready_low_seen == 0) begin
      bad++;
      $display("FAIL in_ready_drop: got 0 stalled cycles want >0");
    end

    // Reset with both stages full.
    out_ready = 1'b0;
    send(16'hAAAA, 16'h1111, 1'b0);
    send(16'h5555, 16'h2222, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    check_reset_state("reset_midflight");
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    lat_check = 1'b1;
    send(16'h1234, 16'h0001, 1'b0);
    drain("drain_after_reset");
    lat_check = 1'b0;

    // Random ops with random gaps and random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
          bb = 16'($urandom);
          ss = 1'($urandom_range(1));
          send(16'($urandom), ss ? ~bb : bb, ss);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/addsub_16b_pipe.md
Name: addsub_16b_pipe

Overview:
- Execute-stage 16-bit add/subtract unit, directly downstream of the 16-bit ones'-complement inverter (negBit = subtract select).
- Consumes operand A and the conditionally inverted operand B; applies carry-in = sub to complete two's-complement subtraction.
- Two-stage pipeline: low byte in stage 1, high byte plus flags in stage 2, with a carry register between them.
- Valid/ready handshakes on both sides; full throughput of one op per cycle.

Parameters:
- WIDTH, 16, operand/result width; only 16 is supported.
- SPLIT, 8, bit position where the carry is registered between stage 1 and stage 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream presents an op.
- in_ready  output  1  unit accepts the op this cycle.
- a  input  16  operand A.
- b_inv  input  16  operand B after the inverter (~B when sub=1, B when sub=0).
- sub  input  1  1 = subtract; used as carry-in.
- out_valid  output  1  result registers hold a valid op.
- out_ready  input  1  downstream consumes the result this cycle.
- sum  output  16  result.
- cout  output  1  carry out of bit 15; for subtract, 1 = no borrow.
- ofl  output  1  signed overflow.
- zero  output  1  sum == 0.
- neg  output  1  sum[15].

Behaviour:
- Reset: rst=0 at posedge clears both stage valids; out_valid, sum, cout, ofl, zero and neg all go to 0. in_ready reads 1 on the first cycle after reset. Reset overrides any in-flight or handshaking op; in-flight ops are dropped.
- Handshake:
  - Accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - s2_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_adv (combinational; no dependence on in_valid).
- Stage 1, on accept:
  - Register {c8, lo} = a[7:0] + b_inv[7:0] + sub (9-bit add).
  - Register a[15:8], b_inv[15:8], and s1_valid=1.
  - With no accept while s2_adv=1, s1_valid clears.
  - While stalled, stage 1 holds its data.
- Stage 2, when s2_adv && s1_valid:
  - {cout, hi} = a_hi + b_hi + c8; sum = {hi, lo}.
  - ofl = (a[15] == b_inv[15]) && (sum[15] != a[15]).
  - zero and neg are derived from the final sum.
  - out_valid=1.
- If s2_adv && !s1_valid, out_valid clears. The flag/sum registers may hold stale data while out_valid=0.
- Stall: while out_valid && !out_ready, sum and all flags are held stable. Stage 1 may still fill if it is empty.
- Latency: 2 cycles from accept to out_valid, with no stalls.
- Simultaneous events: accept and a stage-1-to-stage-2 move in the same cycle are legal and keep full throughput. Ops are never dropped, duplicated or reordered.
- Arithmetic wraps modulo 2^16; there are no X/don't-care outputs when out_valid=1.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: on ofl=1, sum saturates to 0x7FFF when a[15]=0, or 0x8000 when a[15]=1. ofl is still reported as 1; zero/neg are computed on the saturated value; cout is unchanged. Latency is unchanged.
- Undefined: sum wraps; no extra logic.

Test Plan:
- Add with inter-byte carry: a=0x00FF, b_inv=0x0001, sub=0 -> 2 cycles later out_valid=1, sum=0x0100, cout=0, ofl=0, zero=0, neg=0.
- Subtract equal: a=0x0005, B=0x0005 (b_inv=0xFFFA), sub=1 -> sum=0x0000, cout=1, zero=1, ofl=0.
- Signed overflow: a=0x7FFF, b_inv=0x0001, sub=0 ->
  - Macro undefined: sum=0x8000, ofl=1, neg=1.
  - ADDSUB_SAT_EN: sum=0x7FFF, ofl=1, neg=0.
- Borrow: a=0x0003, B=0x0005, sub=1 -> sum=0xFFFE, cout=0, neg=1.
- Backpressure: stream 4 ops back-to-back with out_ready=0 for cycles 2-5.
  - in_ready drops once both stages are full; sum/flags stay constant during the stall.
  - After out_ready=1, all 4 results emerge in order, each exactly once.
- Reset mid-flight: both stages valid, drive rst=0 for one posedge -> next cycle out_valid=0, sum=0, in_ready=1. The subsequent op a=0x1234, b_inv=0x0001 yields 0x1235.
